// File: rtl/lfsr_prbs_arbiter.sv
// Round-robin arbiter that shares one Fibonacci LFSR between NREQ requesters.
// Each grant streams LFSR states to the owner over valid/ready until its burst completes.
module lfsr_prbs_arbiter #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001,
  parameter int              NREQ  = 4,
  parameter int              LEN_W = 4,
  localparam int             IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic                  seed_we,
  input  logic [WIDTH-1:0]      seed_in,
  input  logic                  data_ready,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic                  seed_err
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [IDW-1:0]   r_rrPtr;
  logic [IDW-1:0]   r_gntIdx;
  logic [NREQ-1:0]  r_gnt;
  logic [LEN_W-1:0] r_lenQ;
  logic [LEN_W-1:0] r_count;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [IDW-1:0]   r_doneId;
  logic             r_seedErr;

  logic             w_hs;
  logic [WIDTH-1:0] w_lfsrNext;
  logic             w_selValid;
  logic [IDW-1:0]   w_selIdx;
  logic [IDW-1:0]   w_nextPtr;

  assign w_hs       = r_valid & data_ready;
  assign w_lfsrNext = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
  assign w_nextPtr  = (int'(r_gntIdx) == NREQ - 1) ? '0 : r_gntIdx + 1'b1;

  // First set request at or above the round-robin pointer, wrapping past NREQ-1.
  always_comb begin
    logic [IDW:0] w_sum;
    w_selValid = 1'b0;
    w_selIdx   = '0;
    w_sum      = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_rrPtr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
      if (!w_selValid && req[w_sum[IDW-1:0]]) begin
        w_selValid = 1'b1;
        w_selIdx   = w_sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_lfsr    <= SEED;
      r_rrPtr   <= '0;
      r_gntIdx  <= '0;
      r_gnt     <= '0;
      r_lenQ    <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_doneId  <= '0;
      r_seedErr <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_seedErr <= 1'b0;

      // A zero seed would lock the LFSR, and reseeding mid-stream would corrupt a burst.
      if (seed_we) begin
        if (r_state == IDLE && seed_in != '0) r_lfsr    <= seed_in;
        else                                  r_seedErr <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_selValid) begin
            r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_selIdx;
            r_gntIdx <= w_selIdx;
            r_lenQ   <= len[w_selIdx*LEN_W +: LEN_W];
            r_count  <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= BURST;
          end
        end

        BURST: begin
          if (w_hs) r_lfsr <= w_lfsrNext;
          // A dropped request wins over a same-cycle handshake: abort without done.
          if (!req[r_gntIdx]) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_rrPtr <= w_nextPtr;
            r_state <= IDLE;
          end else if (w_hs) begin
            r_count <= r_count + 1'b1;
            if (r_count == r_lenQ) begin
              r_gnt    <= '0;
              r_valid  <= 1'b0;
              r_done   <= 1'b1;
              r_doneId <= r_gntIdx;
              r_rrPtr  <= w_nextPtr;
              r_state  <= DONE;
            end
          end
        end

        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign data_out   = r_lfsr;
  assign data_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign done_id    = r_doneId;
  assign seed_err   = r_seedErr;

endmodule

// File: tb/tb_lfsr_prbs_arbiter.sv
// Scoreboard bench for lfsr_prbs_arbiter: expected {gnt,word} and done ids are queued
// as bursts are requested and popped by a monitor on every handshake / done pulse.
module tb_lfsr_prbs_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] len;
  logic        seed_we;
  logic [3:0]  seed_in;
  logic        data_ready;
  logic [3:0]  gnt;
  logic [3:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        seed_err;

  int          numChecks = 0;
  int          numFails  = 0;
  logic [7:0]  expQ[$];
  int          doneQ[$];
  logic [3:0]  modelLfsr;

  lfsr_prbs_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .len        (len),
    .seed_we    (seed_we),
    .seed_in    (seed_in),
    .data_ready (data_ready),
    .gnt        (gnt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .seed_err   (seed_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] lfsrStep(input logic [3:0] s);
    return {s[2:0], ^(s & 4'b1100)};
  endfunction

  // Queue the words requester id should see; aborted bursts get no done entry.
  task automatic expectBurst(input int id, input int words, input bit withDone);
    for (int k = 0; k < words; k++) begin
      expQ.push_back({4'(1 << id), modelLfsr});
      modelLfsr = lfsrStep(modelLfsr);
    end
    if (withDone) doneQ.push_back(id);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l, input logic rdy);
    @(posedge clk);
    #1;
    req        = r;
    len        = l;
    data_ready = rdy;
  endtask

  task automatic waitDone(input int maxCycles);
    bit seen = 1'b0;
    for (int k = 0; k < maxCycles && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    checkOutput("done seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    req = '0; len = '0; data_ready = 1'b0; seed_we = 1'b0; seed_in = '0;
    #2;
    rst = 1'b1;
    modelLfsr = 4'b0001;
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    int         id;
    if (rst) begin
      checkOutput("gnt onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      checkOutput("valid matches gnt", {31'd0, data_valid}, {31'd0, |gnt});
      if (data_valid && data_ready) begin
        if (expQ.size() == 0) checkOutput("unexpected word", {24'd0, gnt, data_out}, 32'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("word", {24'd0, gnt, data_out}, {24'd0, e});
        end
      end
      if (done) begin
        if (doneQ.size() == 0) checkOutput("unexpected done", {31'd0, done}, 32'd0);
        else begin
          id = doneQ.pop_front();
          checkOutput("done_id", {30'd0, done_id}, id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; req = '0; len = '0; seed_we = 1'b0; seed_in = '0; data_ready = 1'b0;
    modelLfsr = 4'b0001;
    #12;
    checkOutput("reset gnt", {28'd0, gnt}, 32'd0);
    checkOutput("reset valid", {31'd0, data_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset done_id", {30'd0, done_id}, 32'd0);
    checkOutput("reset seed_err", {31'd0, seed_err}, 32'd0);
    checkOutput("reset data_out", {28'd0, data_out}, 32'h1);
    rst = 1'b1;

    // Single 3-word burst to requester 0
    expectBurst(0, 3, 1);
    applyStimulus(4'b0001, 16'h0002, 1'b1);
    @(negedge clk);
    checkOutput("gnt in request cycle", {28'd0, gnt}, 32'd0);
    @(negedge clk);
    checkOutput("gnt after 1 cycle", {28'd0, gnt}, 32'b0001);
    waitDone(10);
    checkOutput("lfsr after burst", {28'd0, data_out}, 32'b1001);
    checkOutput("busy in DONE", {31'd0, busy}, 32'd1);
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("busy after DONE", {31'd0, busy}, 32'd0);
    checkOutput("done one cycle", {31'd0, done}, 32'd0);
    checkOutput("done_id held", {30'd0, done_id}, 32'd0);

    // All requesters, single-word bursts: round-robin 0,1,2,3,0
    doReset();
    expectBurst(0, 1, 1); expectBurst(1, 1, 1); expectBurst(2, 1, 1);
    expectBurst(3, 1, 1); expectBurst(0, 1, 1);
    applyStimulus(4'b1111, 16'h0000, 1'b1);
    for (int k = 0; k < 5; k++) waitDone(10);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Backpressure on a 2-word burst to requester 2
    doReset();
    expectBurst(2, 2, 1);
    applyStimulus(4'b0100, 16'h0100, 1'b1);
    applyStimulus(4'b0100, 16'h0100, 1'b0);
    @(negedge clk);
    checkOutput("hold word 1", {28'd0, data_out}, 32'b0001);
    applyStimulus(4'b0100, 16'h0100, 1'b0);
    @(negedge clk);
    checkOutput("hold word 2", {28'd0, data_out}, 32'b0001);
    applyStimulus(4'b0100, 16'h0100, 1'b1);
    waitDone(10);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Abort requester 1 after one of four words, then check the pointer moved past it
    doReset();
    expectBurst(1, 1, 0);
    applyStimulus(4'b0010, 16'h0030, 1'b1);
    applyStimulus(4'b0010, 16'h0030, 1'b1);
    applyStimulus(4'b0000, 16'h0030, 1'b0);
    applyStimulus(4'b0000, 16'h0030, 1'b0);
    @(negedge clk);
    checkOutput("abort gnt", {28'd0, gnt}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort lfsr", {28'd0, data_out}, 32'b0010);
    expectBurst(2, 1, 1); expectBurst(3, 1, 1); expectBurst(1, 1, 1);
    applyStimulus(4'b1110, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++) waitDone(10);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Valid seed in IDLE
    @(posedge clk); #1; seed_we = 1'b1; seed_in = 4'b1000;
    @(posedge clk); #1; seed_we = 1'b0;
    @(negedge clk);
    checkOutput("seed loaded", {28'd0, data_out}, 32'b1000);
    checkOutput("seed no err", {31'd0, seed_err}, 32'd0);
    modelLfsr = 4'b1000;
    expectBurst(0, 2, 1);
    applyStimulus(4'b0001, 16'h0001, 1'b1);
    waitDone(10);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Zero seed is rejected
    @(posedge clk); #1; seed_we = 1'b1; seed_in = 4'b0000;
    @(posedge clk); #1; seed_we = 1'b0;
    @(negedge clk);
    checkOutput("zero seed err", {31'd0, seed_err}, 32'd1);
    checkOutput("zero seed ignored", {28'd0, data_out}, {28'd0, modelLfsr});
    @(negedge clk);
    checkOutput("seed_err pulse", {31'd0, seed_err}, 32'd0);

    // Seed during BURST is rejected
    applyStimulus(4'b0001, 16'h0000, 1'b0);
    applyStimulus(4'b0001, 16'h0000, 1'b0);
    seed_we = 1'b1; seed_in = 4'b0110;
    @(posedge clk); #1; seed_we = 1'b0;
    @(negedge clk);
    checkOutput("burst seed err", {31'd0, seed_err}, 32'd1);
    checkOutput("burst seed ignored", {28'd0, data_out}, {28'd0, modelLfsr});
    expectBurst(0, 1, 1);
    applyStimulus(4'b0001, 16'h0000, 1'b1);
    waitDone(10);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Seed and arbitration on the same IDLE edge
    applyStimulus(4'b0001, 16'h0000, 1'b1);
    seed_we = 1'b1; seed_in = 4'b0111;
    modelLfsr = 4'b0111;
    expectBurst(0, 1, 1);
    @(posedge clk); #1; seed_we = 1'b0;
    waitDone(10);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Asynchronous reset in the middle of a burst
    applyStimulus(4'b0100, 16'h0500, 1'b0);
    applyStimulus(4'b0100, 16'h0500, 1'b0);
    @(negedge clk);
    checkOutput("pre-reset gnt", {28'd0, gnt}, 32'b0100);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst gnt", {28'd0, gnt}, 32'd0);
    checkOutput("async rst valid", {31'd0, data_valid}, 32'd0);
    checkOutput("async rst busy", {31'd0, busy}, 32'd0);
    checkOutput("async rst lfsr", {28'd0, data_out}, 32'b0001);
    req = 4'b1111; len = 16'h0000; data_ready = 1'b1;
    modelLfsr = 4'b0001;
    expectBurst(0, 1, 1);
    rst = 1'b1;
    waitDone(10);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("word queue drained", expQ.size(), 32'd0);
    checkOutput("done queue drained", doneQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
